// File: rtl/ecc_seq_pkg.sv
// Shared constants and types for the ECC job sequencer: register map, CTRL modes,
// FSM states and the ordered register-write list.
package ecc_seq_pkg;

  localparam int APB_ADDR_W = 20;

  localparam logic [APB_ADDR_W-1:0] ADDR_CTRL           = 20'h0;
  localparam logic [APB_ADDR_W-1:0] ADDR_DATA_IN        = 20'h4;
  localparam logic [APB_ADDR_W-1:0] ADDR_CODEWORD_WIDTH = 20'h8;
  localparam logic [APB_ADDR_W-1:0] ADDR_NOISE          = 20'hC;

  localparam logic [1:0] ENCODER_ONLY = 2'b00;
  localparam logic [1:0] DECODER_ONLY = 2'b01;
  localparam logic [1:0] FULL_CHANNEL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT_DONE,
    ST_RESULT
  } seq_state_e;

  // Bit position in the need mask doubles as the issue order.
  typedef enum logic [1:0] {
    WR_NOISE = 2'd0,
    WR_WIDTH = 2'd1,
    WR_DATA  = 2'd2,
    WR_CTRL  = 2'd3
  } wr_idx_e;

  function automatic logic [1:0] ctrl_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? FULL_CHANNEL : mode;
  endfunction

  // Lowest needed write at or after position 'from'; CTRL is always needed.
  function automatic wr_idx_e first_wr(input logic [3:0] need, input int from);
    first_wr = WR_CTRL;
    for (int i = 3; i >= 0; i--) begin
      if (i >= from && need[i]) first_wr = wr_idx_e'(i);
    end
  endfunction

endpackage

// File: rtl/ecc_seq_apb_wr.sv
// Two-phase APB write engine: a start pulse loads SETUP, the next cycle is ACCESS,
// and done is high during ACCESS so a new start can follow with no idle cycle.
module ecc_seq_apb_wr #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AMBA_ADDR_WIDTH-1:0] addr,
  input  logic [AMBA_WORD-1:0]       data,
  output logic                       done,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA
);

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else if (start) begin
      PSEL    <= 1'b1;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b1;
      PADDR   <= addr;
      PWDATA  <= data;
    end else if (PSEL && !PENABLE) begin
      PENABLE <= 1'b1;
    end else begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
    end
  end

  assign done = PSEL & PENABLE;

endmodule

// File: rtl/ecc_job_sequencer.sv
// Drives the ECC_ENC_DEC APB slave for one requester: writes NOISE/CODEWORD_WIDTH/
// DATA_IN/CTRL (skipping cached values), waits for operation_done, returns the result.
module ecc_job_sequencer
  import ecc_seq_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int DONE_TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [1:0]                 job_mode,
  input  logic [1:0]                 job_width,
  input  logic [AMBA_WORD-1:0]       job_data,
  input  logic [AMBA_WORD-1:0]       job_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [1:0]                 res_errors,
  output logic                       res_timeout,
  output logic                       busy
);

  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

  seq_state_e state_q, state_d;
  wr_idx_e    idx_q, wr_sel;
  logic [3:0] need_q, need_new;
  logic [1:0] mode_q, width_q, src_mode, src_width, width_sh;
  logic [AMBA_WORD-1:0] data_q, noise_q, src_data, src_noise, noise_sh;
  logic noise_sh_v, width_sh_v;
  logic [CNT_W-1:0] cnt_q;
  logic [AMBA_ADDR_WIDTH-1:0] wr_addr;
  logic [AMBA_WORD-1:0]       wr_data;
  logic accept, more, start, wr_done, terminal;

  assign accept   = job_valid && (state_q == ST_IDLE);
  assign more     = (idx_q != WR_CTRL);
  assign start    = accept || (state_q == ST_ACCESS && more);
  assign terminal = (cnt_q == CNT_W'(DONE_TIMEOUT));
  assign need_new = {2'b11, !(width_sh_v && width_sh == job_width),
                     !(noise_sh_v && noise_sh == job_noise)};

  // In IDLE the first entry comes straight from the job inputs so SETUP follows acceptance.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    wr_sel    = first_wr(need_q, int'(idx_q) + 1);
    src_mode  = mode_q;
    src_width = width_q;
    src_data  = data_q;
    src_noise = noise_q;
    if (state_q == ST_IDLE) begin
      wr_sel    = first_wr(need_new, 0);
      src_mode  = ctrl_mode(job_mode);
      src_width = job_width;
      src_data  = job_data;
      src_noise = job_noise;
    end
    wr_addr = AMBA_ADDR_WIDTH'(ADDR_CTRL);
    wr_data = AMBA_WORD'(src_mode);
    unique case (wr_sel)
      WR_NOISE: begin wr_addr = AMBA_ADDR_WIDTH'(ADDR_NOISE);          wr_data = src_noise; end
      WR_WIDTH: begin wr_addr = AMBA_ADDR_WIDTH'(ADDR_CODEWORD_WIDTH); wr_data = AMBA_WORD'(src_width); end
      WR_DATA:  begin wr_addr = AMBA_ADDR_WIDTH'(ADDR_DATA_IN);        wr_data = src_data; end
      WR_CTRL:  begin wr_addr = AMBA_ADDR_WIDTH'(ADDR_CTRL);           wr_data = AMBA_WORD'(src_mode); end
    endcase
  end

  ecc_seq_apb_wr #(.AMBA_WORD(AMBA_WORD), .AMBA_ADDR_WIDTH(AMBA_ADDR_WIDTH)) u_apb_wr (
    .clk(clk), .rst(rst), .start(start), .addr(wr_addr), .data(wr_data), .done(wr_done),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (accept) state_d = ST_SETUP;
      ST_SETUP:     state_d = ST_ACCESS;
      ST_ACCESS:    state_d = more ? ST_SETUP : ST_WAIT_DONE;
      ST_WAIT_DONE: if (operation_done || terminal) state_d = ST_RESULT;
      ST_RESULT:    if (res_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    job_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    res_valid = (state_q == ST_RESULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= WR_NOISE;
      need_q      <= '0;
      mode_q      <= '0;
      width_q     <= '0;
      data_q      <= '0;
      noise_q     <= '0;
      noise_sh    <= '0;
      width_sh    <= '0;
      noise_sh_v  <= 1'b0;
      width_sh_v  <= 1'b0;
      cnt_q       <= '0;
      res_data    <= '0;
      res_errors  <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (accept) begin
        mode_q  <= ctrl_mode(job_mode);
        width_q <= job_width;
        data_q  <= job_data;
        noise_q <= job_noise;
        need_q  <= need_new;
      end
      if (start) idx_q <= wr_sel;
      if (wr_done && idx_q == WR_NOISE) begin
        noise_sh   <= noise_q;
        noise_sh_v <= 1'b1;
      end
      if (wr_done && idx_q == WR_WIDTH) begin
        width_sh   <= width_q;
        width_sh_v <= 1'b1;
      end
      cnt_q <= (state_q == ST_WAIT_DONE) ? cnt_q + 1'b1 : '0;
      // A done arriving on the terminal count still counts as a normal result.
      if (state_q == ST_WAIT_DONE && operation_done) begin
        res_data    <= data_out;
        res_errors  <= num_of_errors;
        res_timeout <= 1'b0;
      end else if (state_q == ST_WAIT_DONE && terminal) begin
        res_data    <= '0;
        res_errors  <= '0;
        res_timeout <= 1'b1;
        noise_sh_v  <= 1'b0;
        width_sh_v  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ecc_job_sequencer.sv
// Self-checking bench for ecc_job_sequencer: directed job table, mid-job reset and
// randomized jobs checked against a register-cache reference model.
module tb_ecc_job_sequencer;

  localparam int DONE_TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [1:0]  job_mode, job_width;
  logic [31:0] job_data, job_noise;
  logic [19:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_errors;
  logic        res_timeout, busy;

  always #5 clk = ~clk;

  ecc_job_sequencer #(
    .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .DONE_TIMEOUT(DONE_TO)
  ) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_mode(job_mode), .job_width(job_width), .job_data(job_data), .job_noise(job_noise),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_errors(res_errors), .res_timeout(res_timeout), .busy(busy)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  width;
    logic [31:0] data;
    logic [31:0] noise;
    int          done_dly;  // cycles after CTRL ACCESS; 0 = never
    int          hold;      // cycles res_ready stays low
    int          spur;      // cycle of a stray done during the APB phase; -1 = none
    logic [31:0] dout;
    logic [1:0]  nerr;
    int          exp_wr;
    logic        exp_to;
  } vec_t;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
  } wr_t;

  int errors = 0;
  int checks = 0;

  // Reference model of what the slave registers currently hold.
  logic [31:0] m_noise;
  logic [1:0]  m_width;
  bit          m_nv, m_wv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, output int n_wr, output logic got_to);
    wr_t         exp_q[$];
    wr_t         got_q[$];
    int          t, tc, exp_rv;
    bit          in_setup, to;
    logic [19:0] s_addr;
    logic [31:0] s_data, exp_data;
    logic [1:0]  exp_err, exp_ctrl;

    exp_ctrl = (v.mode == 2'b11) ? 2'b10 : v.mode;
    if (!(m_nv && m_noise == v.noise)) exp_q.push_back('{20'hC, v.noise});
    if (!(m_wv && m_width == v.width)) exp_q.push_back('{20'h8, {30'b0, v.width}});
    exp_q.push_back('{20'h4, v.data});
    exp_q.push_back('{20'h0, {30'b0, exp_ctrl}});
    to       = !(v.done_dly >= 1 && v.done_dly <= DONE_TO + 1);
    exp_data = to ? 32'h0 : v.dout;
    exp_err  = to ? 2'd0 : v.nerr;

    check("job_ready_idle", job_ready, 1);
    job_valid = 1'b1;
    job_mode  = v.mode;
    job_width = v.width;
    job_data  = v.data;
    job_noise = v.noise;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    job_mode  = 2'($urandom);
    job_width = 2'($urandom);
    job_data  = $urandom;
    job_noise = $urandom;

    t = 1;
    tc = -1;
    in_setup = 1'b0;
    s_addr = '0;
    s_data = '0;
    while (t < 200) begin
      operation_done = 1'b0;
      if (res_valid) break;
      if (PSEL && !PENABLE) begin
        check("setup_cycle", 64'(t), 64'(1 + 2 * got_q.size()));
        s_addr = PADDR;
        s_data = PWDATA;
        in_setup = 1'b1;
      end else if (PSEL && PENABLE) begin
        check("access_after_setup", {in_setup, PWRITE, PADDR == s_addr, PWDATA == s_data}, 4'hF);
        got_q.push_back('{PADDR, PWDATA});
        in_setup = 1'b0;
        if (PADDR == 20'h0) tc = t;
      end
      if (t == v.spur) begin
        operation_done = 1'b1;
        data_out       = 32'hDEADBEEF;
        num_of_errors  = 2'd3;
      end
      if (tc >= 0 && v.done_dly >= 1 && t == tc + v.done_dly) begin
        operation_done = 1'b1;
        data_out       = v.dout;
        num_of_errors  = v.nerr;
      end
      @(negedge clk);
      t++;
    end
    check("res_valid_seen", res_valid, 1);

    check("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("write%0d", i), {got_q[i].addr, got_q[i].data}, {exp_q[i].addr, exp_q[i].data});
    exp_rv = to ? tc + DONE_TO + 2 : tc + v.done_dly + 1;
    check("res_valid_cycle", 64'(t), 64'(exp_rv));
    check("res_fields", {res_timeout, res_errors, res_data}, {to, exp_err, exp_data});
    check("result_busy_ready", {busy, job_ready}, 2'b10);
    got_to = res_timeout;

    res_ready = 1'b0;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check("res_hold", {res_valid, res_timeout, res_errors, res_data}, {1'b1, to, exp_err, exp_data});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_after_res", {res_valid, job_ready, busy}, 3'b010);

    m_noise = v.noise;
    m_width = v.width;
    m_nv    = !to;
    m_wv    = !to;
    n_wr    = got_q.size();
  endtask

  vec_t tbl[7];
  vec_t r;
  int   n;
  logic tto;
  bit   found;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    job_valid = 1'b0;
    job_mode = '0;
    job_width = '0;
    job_data = '0;
    job_noise = '0;
    operation_done = 1'b0;
    data_out = '0;
    num_of_errors = '0;
    res_ready = 1'b0;
    m_noise = '0;
    m_width = '0;
    m_nv = 1'b0;
    m_wv = 1'b0;

    tbl[0] = '{2'b10, 2'd0, 32'hAE,   32'h22, 3,  5, -1, 32'hAE,   2'd1, 4, 1'b0};
    tbl[1] = '{2'b10, 2'd0, 32'hAE,   32'h22, 3,  1, -1, 32'hAE,   2'd1, 2, 1'b0};
    tbl[2] = '{2'b11, 2'd0, 32'h5A5A, 32'h22, 9,  0, -1, 32'h1234, 2'd2, 2, 1'b0};
    tbl[3] = '{2'b01, 2'd1, 32'h77,   32'h22, 0,  2, -1, 32'h0,    2'd0, 3, 1'b1};
    tbl[4] = '{2'b00, 2'd1, 32'h88,   32'h22, 1,  0, -1, 32'hCAFE, 2'd3, 4, 1'b0};
    tbl[5] = '{2'b00, 2'd1, 32'h99,   32'h33, 10, 1, -1, 32'hF00D, 2'd1, 3, 1'b1};
    tbl[6] = '{2'b01, 2'd2, 32'h4242, 32'h7,  2,  0,  2, 32'h4242, 2'd0, 4, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_ctl", {job_ready, PSEL, PENABLE, PWRITE, busy, res_valid, res_timeout}, 7'b1000000);
    check("rst_apb_bus", {PADDR, PWDATA}, 52'h0);
    check("rst_res", {res_errors, res_data}, 34'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i], n, tto);
      check($sformatf("tbl%0d_nwr", i), 64'(n), 64'(tbl[i].exp_wr));
      check($sformatf("tbl%0d_timeout", i), tto, tbl[i].exp_to);
    end

    // Reset during the DATA_IN SETUP must drop the bus at once and clear the cache.
    job_valid = 1'b1;
    job_mode  = 2'b10;
    job_width = 2'd3;
    job_data  = 32'h1234;
    job_noise = 32'h99;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (PSEL && !PENABLE && PADDR == 20'h4) found = 1'b1;
      else @(negedge clk);
    end
    check("reached_data_setup", found, 1);
    rst = 1'b1;
    #1;
    check("async_rst_apb", {PSEL, PENABLE, busy, res_valid}, 4'b0);
    @(negedge clk);
    rst = 1'b0;
    m_nv = 1'b0;
    m_wv = 1'b0;
    @(negedge clk);
    check("ready_after_rst", job_ready, 1);
    r = '{2'b10, 2'd3, 32'h1234, 32'h99, 4, 0, -1, 32'h1, 2'd1, 4, 1'b0};
    run_job(r, n, tto);
    check("post_rst_nwr", 64'(n), 64'(4));

    for (int k = 0; k < 25; k++) begin
      r.mode  = 2'($urandom_range(0, 3));
      r.width = 2'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       r.noise = 32'h22;
        1:       r.noise = 32'h33;
        default: r.noise = $urandom;
      endcase
      r.data     = $urandom;
      r.done_dly = int'($urandom_range(0, 11));
      r.hold     = int'($urandom_range(0, 3));
      r.spur     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : -1;
      r.dout     = $urandom;
      r.nerr     = 2'($urandom_range(0, 3));
      r.exp_wr   = 0;
      r.exp_to   = 1'b0;
      run_job(r, n, tto);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
